// File: rtl/blocked_matmul_accel_pkg.sv
// Shared fixed-point constants, element types, pass sequencing states and
// the row-major block index helper for the block matrix-multiply engine.
package blocked_matmul_accel_pkg;

   localparam int unsigned FX_WIDTH = 16;
   localparam int unsigned FX_FRAC  = 8;

   typedef logic signed [FX_WIDTH-1:0]   elem_t;
   typedef logic signed [2*FX_WIDTH-1:0] prod_t;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_RUN,
      ST_DONE
   } pass_state_t;

   function automatic int unsigned blk_idx(input int unsigned r,
                                           input int unsigned c,
                                           input int unsigned n);
      return r * n + c;
   endfunction

endpackage

// File: rtl/blocked_matmul_accel_if.sv
// Block-fetch / controller side bus of the matmul accelerator: A and B chunks
// in, accumulator clear in, finish / done / C block out.
interface blocked_matmul_accel_if
   import blocked_matmul_accel_pkg::*;
#(
   parameter int unsigned WIDTH      = FX_WIDTH,
   parameter int unsigned CHUNK_SIZE = 4
);
   logic                          reset_acc;
   logic [WIDTH*CHUNK_SIZE-1:0]   input_w;
   logic [WIDTH*CHUNK_SIZE-1:0]   input_n;
   logic                          systolic_finish;
   logic                          accumulator_done;
   logic [WIDTH*CHUNK_SIZE-1:0]   out;

   modport master (
      output reset_acc, input_w, input_n,
      input  systolic_finish, accumulator_done, out
   );

   modport slave (
      input  reset_acc, input_w, input_n,
      output systolic_finish, accumulator_done, out
   );
endinterface

// File: rtl/blocked_matmul_accel_pe.sv
// Output-stationary systolic PE: forwards west data east and north data south,
// accumulates the full-width signed product, presents the Q-shifted result.
module systolic_pe #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned FRAC_WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] w_i,
   input  logic [WIDTH-1:0] n_i,
   output logic [WIDTH-1:0] e_o,
   output logic [WIDTH-1:0] s_o,
   output logic [WIDTH-1:0] res_o
);
   logic [WIDTH-1:0]   e_q, s_q;
   logic [2*WIDTH-1:0] sum_q, sum_d;
   logic [2*WIDTH-1:0] w_ext, n_ext, prod;

   // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
   assign w_ext = {{WIDTH{w_i[WIDTH-1]}}, w_i};
   assign n_ext = {{WIDTH{n_i[WIDTH-1]}}, n_i};
   assign prod  = w_ext * n_ext;
   assign sum_d = sum_q + prod;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q   <= '0;
         s_q   <= '0;
         sum_q <= '0;
      end else begin
         e_q   <= w_i;
         s_q   <= n_i;
         sum_q <= sum_d;
      end
   end

   assign e_o   = e_q;
   assign s_o   = s_q;
   assign res_o = sum_q[FRAC_WIDTH +: WIDTH];
endmodule

// File: rtl/blocked_matmul_accel.sv
// Block matmul engine: NxN output-stationary systolic array fed from skewed
// block registers, plus a K-pass block accumulator on a separate sync clear.
module blocked_matmul_accel
   import blocked_matmul_accel_pkg::*;
#(
   parameter int unsigned WIDTH           = FX_WIDTH,
   parameter int unsigned FRAC_WIDTH      = FX_FRAC,
   parameter int unsigned BLOCK_SIZE      = 2,
   parameter int unsigned CHUNK_SIZE      = 4,
   parameter int unsigned INNER_DIMENSION = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   blocked_matmul_accel_if.slave bus
);
   localparam int unsigned N      = BLOCK_SIZE;
   localparam int unsigned K      = INNER_DIMENSION / BLOCK_SIZE;
   localparam int unsigned CNT_W  = $clog2(3 * N);
   localparam int unsigned PASS_W = $clog2(K + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(3 * N - 2);
   localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(K - 1);

   pass_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              armed_q, armed_d;
   logic              load;
   logic              acc_event;

   logic [WIDTH-1:0]  w_skew_q [CHUNK_SIZE];
   logic [WIDTH-1:0]  n_skew_q [CHUNK_SIZE];
   logic [WIDTH-1:0]  west_feed  [N];
   logic [WIDTH-1:0]  north_feed [N];
   logic [WIDTH-1:0]  east  [N][N];
   logic [WIDTH-1:0]  south [N][N];
   logic [WIDTH-1:0]  prod  [CHUNK_SIZE];

   logic [WIDTH-1:0]  acc_q [CHUNK_SIZE];
   logic [PASS_W-1:0] pass_cnt_q;
   logic              done_q;
   logic [WIDTH*CHUNK_SIZE-1:0] out_flat;
   logic              unused_edges;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOAD;
         cnt_q   <= '0;
         armed_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      armed_d = armed_q;
      load    = 1'b0;
      unique case (state_q)
         ST_LOAD: begin
            load    = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = ST_RUN;
         end
         ST_RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = ST_DONE;
         end
         ST_DONE: armed_d = 1'b0;
         default: state_d = ST_LOAD;
      endcase
   end

   assign acc_event           = (state_q == ST_DONE) && armed_q;
   assign bus.systolic_finish = (state_q == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < CHUNK_SIZE; i++) begin
            w_skew_q[i] <= '0;
            n_skew_q[i] <= '0;
         end
      end else if (load) begin
         for (int unsigned i = 0; i < CHUNK_SIZE; i++) begin
            w_skew_q[i] <= bus.input_w[WIDTH*i +: WIDTH];
            n_skew_q[i] <= bus.input_n[WIDTH*i +: WIDTH];
         end
      end
   end

   // Step t = cnt_q-1: row i gets A(i,t-i), column i gets B(t-i,i), i.e. k = cnt_q-1-i.
   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         west_feed[i]  = '0;
         north_feed[i] = '0;
      end
      if (state_q == ST_RUN) begin
         for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned k = 0; k < N; k++) begin
               if (32'(cnt_q) == i + k + 1) begin
                  west_feed[i]  = w_skew_q[blk_idx(i, k, N)];
                  north_feed[i] = n_skew_q[blk_idx(k, i, N)];
               end
            end
         end
      end
   end

   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
         logic [WIDTH-1:0] w_in, n_in;
         if (c == 0) begin : g_wfeed
            assign w_in = west_feed[r];
         end else begin : g_wchain
            assign w_in = east[r][c-1];
         end
         if (r == 0) begin : g_nfeed
            assign n_in = north_feed[c];
         end else begin : g_nchain
            assign n_in = south[r-1][c];
         end
         systolic_pe #(
            .WIDTH      (WIDTH),
            .FRAC_WIDTH (FRAC_WIDTH)
         ) u_pe (
            .clk   (clk),
            .rst_n (rst_n),
            .w_i   (w_in),
            .n_i   (n_in),
            .e_o   (east[r][c]),
            .s_o   (south[r][c]),
            .res_o (prod[r*N+c])
         );
      end
   end

   always_comb begin
      unused_edges = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         unused_edges = unused_edges ^ (^east[i][N-1]) ^ (^south[N-1][i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!bus.reset_acc) begin
         for (int unsigned i = 0; i < CHUNK_SIZE; i++) acc_q[i] <= '0;
         pass_cnt_q <= '0;
         done_q     <= 1'b0;
      end else if (acc_event) begin
         if (done_q) begin
            for (int unsigned i = 0; i < CHUNK_SIZE; i++) acc_q[i] <= prod[i];
            pass_cnt_q <= PASS_W'(1);
            done_q     <= (K == 1);
         end else begin
            for (int unsigned i = 0; i < CHUNK_SIZE; i++) acc_q[i] <= acc_q[i] + prod[i];
            pass_cnt_q <= pass_cnt_q + 1'b1;
            done_q     <= (pass_cnt_q == PASS_LAST);
         end
      end
   end

   always_comb begin
      out_flat = '0;
      for (int unsigned i = 0; i < CHUNK_SIZE; i++) out_flat[WIDTH*i +: WIDTH] = acc_q[i];
   end

   assign bus.out              = out_flat;
   assign bus.accumulator_done = done_q;
endmodule

// File: tb/tb_blocked_matmul_accel.sv
// Directed plus randomized passes against a plain-arithmetic block product
// and accumulation model of the matmul accelerator.
module tb_blocked_matmul_accel;
   import blocked_matmul_accel_pkg::*;

   localparam int unsigned W  = 16;
   localparam int unsigned N  = 2;
   localparam int unsigned CH = 4;
   localparam int unsigned K  = 2;

   localparam logic [63:0] A_ID   = 64'h0100_0000_0000_0100;
   localparam logic [63:0] B_T1   = 64'h0500_0400_0300_0200;
   localparam logic [63:0] A_NEG  = 64'hFF00_FF00_FF00_FF00;
   localparam logic [63:0] HALF   = 64'h0080_0080_0080_0080;
   localparam logic [63:0] LSB    = 64'h0001_0001_0001_0001;
   localparam logic [63:0] ONES   = 64'h0100_0100_0100_0100;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   blocked_matmul_accel_if #(.WIDTH(W), .CHUNK_SIZE(CH)) bus ();

   blocked_matmul_accel #(
      .WIDTH           (W),
      .FRAC_WIDTH      (8),
      .BLOCK_SIZE      (N),
      .CHUNK_SIZE      (CH),
      .INNER_DIMENSION (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   logic [63:0] m_acc;
   int          m_cnt;
   bit          m_done;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // C(i,j) = (sum_k A(i,k)*B(k,j)) >>> 8, low 16 bits kept.
   function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
      logic [63:0] r;
      logic [15:0] ea, eb;
      longint      s;
      r = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++) begin
               ea = a[16*(i*N+k) +: 16];
               eb = b[16*(k*N+j) +: 16];
               s += longint'($signed(ea)) * longint'($signed(eb));
            end
            s = s >>> 8;
            r[16*(i*N+j) +: 16] = s[15:0];
         end
      end
      return r;
   endfunction

   function automatic logic [63:0] ref_add(input logic [63:0] a, input logic [63:0] b);
      logic [63:0] r;
      for (int i = 0; i < CH; i++) r[16*i +: 16] = a[16*i +: 16] + b[16*i +: 16];
      return r;
   endfunction

   task automatic model_event(input logic [63:0] p);
      if (m_done) begin
         m_acc  = p;
         m_cnt  = 1;
         m_done = (K == 1);
      end else begin
         m_acc  = ref_add(m_acc, p);
         m_cnt++;
         m_done = (m_cnt == K);
      end
   endtask

   task automatic run_pass(input logic [63:0] a, input logic [63:0] b,
                           input int abort_at, input bit clr_at_event, input string tag);
      @(negedge clk);
      rst_n       = 1'b0;
      bus.input_w = a;
      bus.input_n = b;
      @(negedge clk);
      check({tag, "_rst_fin"}, 64'(bus.systolic_finish), 64'd0);
      rst_n = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         @(posedge clk);
         #1;
         check($sformatf("%s_fin_e%0d", tag, e), 64'(bus.systolic_finish), (e == 5) ? 64'd1 : 64'd0);
         if (e == abort_at) begin
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check({tag, "_abort_fin"}, 64'(bus.systolic_finish), 64'd0);
            repeat (2) @(posedge clk);
            #1;
            check({tag, "_abort_out"}, bus.out, m_acc);
            check({tag, "_abort_done"}, 64'(bus.accumulator_done), 64'(m_done));
            return;
         end
      end
      @(negedge clk);
      if (clr_at_event) bus.reset_acc = 1'b0;
      @(posedge clk);
      #1;
      if (clr_at_event) begin
         m_acc  = '0;
         m_cnt  = 0;
         m_done = 1'b0;
      end else begin
         model_event(ref_mul(a, b));
      end
      check({tag, "_out"}, bus.out, m_acc);
      check({tag, "_done"}, 64'(bus.accumulator_done), 64'(m_done));
      @(negedge clk);
      bus.reset_acc = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_oneshot_out"}, bus.out, m_acc);
      check({tag, "_hold_fin"}, 64'(bus.systolic_finish), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check({tag, "_rstn_fin"}, 64'(bus.systolic_finish), 64'd0);
      check({tag, "_rstn_out"}, bus.out, m_acc);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] ra, rb;
      int          ab;
      bit          clr;

      rst_n         = 1'b0;
      bus.reset_acc = 1'b0;
      bus.input_w   = '0;
      bus.input_n   = '0;
      repeat (2) @(posedge clk);
      #1;
      check("init_out", bus.out, 64'd0);
      check("init_done", 64'(bus.accumulator_done), 64'd0);
      check("init_fin", 64'(bus.systolic_finish), 64'd0);
      m_acc  = '0;
      m_cnt  = 0;
      m_done = 1'b0;
      @(negedge clk);
      bus.reset_acc = 1'b1;

      run_pass(A_ID, B_T1, 0, 1'b0, "t1p1");
      check("t1p1_done_const", 64'(bus.accumulator_done), 64'd0);
      run_pass(A_ID, B_T1, 0, 1'b0, "t1p2");
      check("t1_out_const", bus.out, 64'h0A00_0800_0600_0400);
      check("t1_done_const", 64'(bus.accumulator_done), 64'd1);

      run_pass(A_NEG, A_ID, 0, 1'b0, "t2p1");
      run_pass(A_NEG, A_ID, 0, 1'b0, "t2p2");
      check("t2_out_const", bus.out, 64'hFE00_FE00_FE00_FE00);

      run_pass(HALF, HALF, 0, 1'b0, "t3ap1");
      run_pass(HALF, HALF, 0, 1'b0, "t3ap2");
      check("t3a_out_const", bus.out, 64'h0100_0100_0100_0100);
      run_pass(LSB, LSB, 0, 1'b0, "t3bp1");
      run_pass(LSB, LSB, 0, 1'b0, "t3bp2");
      check("t3b_out_const", bus.out, 64'd0);

      run_pass(B_T1, B_T1, 3, 1'b0, "t4abort");
      run_pass(A_ID, B_T1, 0, 1'b0, "t4full");
      check("t4_out_const", bus.out, B_T1);

      run_pass(A_ID, B_T1, 0, 1'b1, "t5clr");
      check("t5_clr_out_const", bus.out, 64'd0);
      run_pass(A_ID, B_T1, 0, 1'b0, "t5p1");
      run_pass(A_ID, B_T1, 0, 1'b0, "t5p2");
      check("t5_out_const", bus.out, 64'h0A00_0800_0600_0400);

      run_pass(A_ID, ONES, 0, 1'b0, "t6");
      check("t6_out_const", bus.out, ONES);
      check("t6_done_const", 64'(bus.accumulator_done), 64'd0);

      for (int p = 0; p < 12; p++) begin
         ra  = {$urandom(), $urandom()};
         rb  = {$urandom(), $urandom()};
         clr = ($urandom_range(0, 5) == 0);
         ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
         run_pass(ra, rb, ab, clr, $sformatf("rnd%0d", p));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
